core_stack: RTL and testbench
=============================

Name: core_stack

Overview:
- Per-core operand stack (LIFO) directly downstream of the word fetch/decode sequencer.
- Consumes that sequencer's assembled literal push (56-bit `push_value` / `push_en`) and stack-manipulation ops decoded from CPU instruction words.
- Exposes top-of-stack (TOS) and next-of-stack (NOS) to the core ALU.
- Reports `idle` so the sequencer's wait state knows when the next word may be issued.

Parameters:
- WIDTH, 56: data word width; matches the sequencer's 56-bit read accumulator.
- DEPTH, 16: total stack capacity in entries, TOS and NOS included; must be >= 3.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- push_en  input  1  push `push_value` this cycle
- push_value  input  WIDTH  literal to push
- op_en  input  1  execute `op` this cycle
- op  input  3  0 NOP, 1 DROP, 2 DUP, 3 SWAP, 4 OVER, 5 CLEAR, 6-7 treated as NOP
- tos  output  WIDTH  top of stack (0 when depth==0)
- nos  output  WIDTH  second entry (0 when depth<2)
- depth  output  $clog2(DEPTH+1)  current entry count
- empty  output  1  depth==0
- full  output  1  depth==DEPTH
- idle  output  1  ready to accept a request
- overflow  output  1  sticky: push/DUP/OVER attempted while full
- underflow  output  1  sticky: op attempted with too few entries
- hwm  output  $clog2(DEPTH+1)  high-water mark (see Optional Feature)

Behaviour:
- Storage:
  - `tos` and `nos` are registers.
  - Entries 3..DEPTH live in a DEPTH-2 entry synchronous-read RAM, with spill pointer `sp` (next free slot).
- Reset (async, rst=1): state S_IDLE; tos, nos, depth, sp, overflow, underflow, hwm all 0; idle=1.
- States:
  - S_IDLE: idle=1.
  - S_FILL: idle=0, exactly one cycle.
- Request acceptance:
  - Requests are sampled only in S_IDLE.
  - push_en/op_en in S_FILL are ignored with no error flag set; the sequencer must wait for `idle`.
  - push_en and op_en together: push executes, op is discarded.
- PUSH / DUP / OVER ("push-class"; value is push_value / tos / nos respectively), 1 cycle, stays S_IDLE:
  - If depth>=2: mem[sp]<=nos, sp<=sp+1.
  - nos<=tos, tos<=value, depth<=depth+1.
  - Requirements: depth<DEPTH, else overflow<=1 and no state change. DUP needs depth>=1 and OVER needs depth>=2, else underflow<=1 and no state change.
- SWAP: requires depth>=2; exchanges tos/nos in 1 cycle. Else underflow<=1, no change.
- DROP: requires depth>=1, else underflow<=1.
  - tos<=nos, depth<=depth-1.
  - If depth>2: issue RAM read at sp-1, go to S_FILL. Next cycle: nos<=RAM data, sp<=sp-1, return to S_IDLE.
  - If depth<=2: nos<=0, single cycle.
- CLEAR: depth, sp, tos, nos <= 0 in 1 cycle; sticky flags unchanged.
- NOP: no effect.
- Error flags: stay set until rst. Errors never corrupt stack contents.
- Timing: tos/nos/depth are registered and valid the cycle after acceptance (DROP with fill: nos valid after S_FILL). empty/full/idle are combinational from registered state.
- Reset mid-S_FILL: aborts the fill; all state returns to reset values.

Optional Feature:
- Macro: CORE_STACK_HWM_EN.
- Defined: `hwm` tracks max depth reached since reset (updated on the same edge depth increases). CLEAR does not lower it.
- Undefined: `hwm` is tied to 0 and the tracking register is not built.

Test Plan:
- DEPTH=4. Push 0x11,0x22,0x33 -> tos=0x33, nos=0x22, depth=3, idle high throughout, RAM slot0=0x11.
- From that state, DROP -> idle low exactly 1 cycle. Then tos=0x22, nos=0x11, depth=2. DROP again -> single cycle, tos=0x11, nos=0, depth=1.
- Push 1,2,3,4 then push 5 -> full=1, overflow=1, tos=4, depth=4 unchanged. CLEAR -> depth=0, overflow still 1.
- Empty stack: SWAP -> underflow=1, depth=0. Push 0xA then OVER -> underflow stays 1, depth=1, tos=0xA.
- Push 0xA,0xB; assert push_en(0xC) with op_en=SWAP same cycle -> tos=0xC, nos=0xB, depth=3. Then DROP and assert push_en during S_FILL -> push ignored, depth=2.
- With CORE_STACK_HWM_EN: push 3, drop 2, push 1 -> hwm=3. Assert rst during S_FILL -> all outputs 0, idle=1.

Source files
------------

// File: rtl/core_stack_if.sv
// Request/status bundle between the fetch/decode sequencer (master) and the
// per-core operand stack (slave).
interface core_stack_if #(
    parameter int WIDTH = 56,
    parameter int DEPTH = 16
) ();
    localparam int DW = $clog2(DEPTH + 1);

    logic             push_en;
    logic [WIDTH-1:0] push_value;
    logic             op_en;
    logic [2:0]       op;
    logic [WIDTH-1:0] tos;
    logic [WIDTH-1:0] nos;
    logic [DW-1:0]    depth;
    logic             empty;
    logic             full;
    logic             idle;
    logic             overflow;
    logic             underflow;
    logic [DW-1:0]    hwm;

    modport master (
        output push_en, push_value, op_en, op,
        input  tos, nos, depth, empty, full, idle, overflow, underflow, hwm
    );

    modport slave (
        input  push_en, push_value, op_en, op,
        output tos, nos, depth, empty, full, idle, overflow, underflow, hwm
    );
endinterface

// File: rtl/core_stack.sv
// Operand stack: TOS/NOS in registers, deeper entries spilled to a sync-read RAM.
// Optional high-water-mark tracking is built when CORE_STACK_HWM_EN is defined.
module core_stack #(
    parameter int WIDTH = 56,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    core_stack_if.slave  bus
);
    localparam int DW    = $clog2(DEPTH + 1);
    localparam int SP_W  = $clog2(DEPTH - 1);
    localparam int RAM_N = DEPTH - 2;
    localparam int AW    = (RAM_N > 1) ? $clog2(RAM_N) : 1;

    localparam logic [DW-1:0]   D_ONE  = DW'(1);
    localparam logic [DW-1:0]   D_TWO  = DW'(2);
    localparam logic [DW-1:0]   D_FULL = DW'(DEPTH);
    localparam logic [SP_W-1:0] SP_ONE = SP_W'(1);

    localparam logic [2:0] OP_DROP  = 3'd1;
    localparam logic [2:0] OP_DUP   = 3'd2;
    localparam logic [2:0] OP_SWAP  = 3'd3;
    localparam logic [2:0] OP_OVER  = 3'd4;
    localparam logic [2:0] OP_CLEAR = 3'd5;

    typedef enum logic {S_IDLE, S_FILL} state_t;

    state_t            state_reg;
    logic [WIDTH-1:0]  tos_reg;
    logic [WIDTH-1:0]  nos_reg;
    logic [DW-1:0]     depth_reg;
    logic [SP_W-1:0]   sp_reg;
    logic              overflow_reg;
    logic              underflow_reg;

    logic [WIDTH-1:0]  mem [RAM_N];
    logic [WIDTH-1:0]  rd_data_reg;

    logic              op_valid;
    logic              dup_op, over_op, swap_op, drop_op, clear_op;
    logic              push_class, push_ok;
    logic              have1, have2;
    logic              unf, ovf;
    logic              mem_we, mem_re;
    logic [WIDTH-1:0]  push_val;
    logic [DW-1:0]     depth_inc;
    logic [SP_W-1:0]   sp_dec;

    always_comb begin
        op_valid   = (state_reg == S_IDLE) && bus.op_en && !bus.push_en;
        dup_op     = op_valid && (bus.op == OP_DUP);
        over_op    = op_valid && (bus.op == OP_OVER);
        swap_op    = op_valid && (bus.op == OP_SWAP);
        drop_op    = op_valid && (bus.op == OP_DROP);
        clear_op   = op_valid && (bus.op == OP_CLEAR);
        push_class = ((state_reg == S_IDLE) && bus.push_en) || dup_op || over_op;

        push_val = bus.push_value;
        if (dup_op)
            push_val = tos_reg;
        else if (over_op)
            push_val = nos_reg;

        have1 = (depth_reg >= D_ONE);
        have2 = (depth_reg >= D_TWO);
        unf   = (dup_op && !have1) || (over_op && !have2) ||
                (swap_op && !have2) || (drop_op && !have1);
        ovf   = push_class && (depth_reg == D_FULL);

        push_ok   = push_class && !unf && !ovf;
        mem_we    = push_ok && have2;
        mem_re    = drop_op && (depth_reg > D_TWO);
        depth_inc = depth_reg + D_ONE;
        sp_dec    = sp_reg - SP_ONE;
    end

    // Spill RAM: no reset so it maps onto block RAM; read data is registered.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[sp_reg[AW-1:0]] <= nos_reg;
        if (mem_re)
            rd_data_reg <= mem[sp_dec[AW-1:0]];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            tos_reg       <= '0;
            nos_reg       <= '0;
            depth_reg     <= '0;
            sp_reg        <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (unf)
                underflow_reg <= 1'b1;
            if (ovf)
                overflow_reg <= 1'b1;

            case (state_reg)
                S_IDLE: begin
                    if (push_ok) begin
                        if (have2)
                            sp_reg <= sp_reg + SP_ONE;
                        nos_reg   <= tos_reg;
                        tos_reg   <= push_val;
                        depth_reg <= depth_inc;
                    end else if (swap_op && have2) begin
                        tos_reg <= nos_reg;
                        nos_reg <= tos_reg;
                    end else if (drop_op && have1) begin
                        tos_reg   <= nos_reg;
                        depth_reg <= depth_reg - D_ONE;
                        // Deeper entries exist: refill NOS from RAM next cycle.
                        if (depth_reg > D_TWO)
                            state_reg <= S_FILL;
                        else
                            nos_reg <= '0;
                    end else if (clear_op) begin
                        tos_reg   <= '0;
                        nos_reg   <= '0;
                        depth_reg <= '0;
                        sp_reg    <= '0;
                    end
                end
                S_FILL: begin
                    nos_reg   <= rd_data_reg;
                    sp_reg    <= sp_dec;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

`ifdef CORE_STACK_HWM_EN
    logic [DW-1:0] hwm_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            hwm_reg <= '0;
        else if (push_ok && (depth_inc > hwm_reg))
            hwm_reg <= depth_inc;
    end

    assign bus.hwm = hwm_reg;
`else
    assign bus.hwm = '0;
`endif

    assign bus.tos       = tos_reg;
    assign bus.nos       = nos_reg;
    assign bus.depth     = depth_reg;
    assign bus.empty     = (depth_reg == '0);
    assign bus.full      = (depth_reg == D_FULL);
    assign bus.idle      = (state_reg == S_IDLE);
    assign bus.overflow  = overflow_reg;
    assign bus.underflow = underflow_reg;
endmodule

// File: tb/tb_core_stack.sv
// Directed bench for core_stack at DEPTH=4: push/drop/fill, errors, request
// collisions, high-water mark and reset during a refill.
module tb_core_stack;
    localparam int WIDTH = 56;
    localparam int DEPTH = 4;

    localparam logic [2:0] NOP   = 3'd0;
    localparam logic [2:0] DROP  = 3'd1;
    localparam logic [2:0] DUP   = 3'd2;
    localparam logic [2:0] SWAP  = 3'd3;
    localparam logic [2:0] OVER  = 3'd4;
    localparam logic [2:0] CLEAR = 3'd5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   passed = 0;
    int   total  = 0;

    core_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    core_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Present one request for one clock edge, then sample 1 time unit later.
    task automatic cyc(input logic pe, input logic [WIDTH-1:0] pv, input logic oe, input logic [2:0] o);
        bus.push_en    = pe;
        bus.push_value = pv;
        bus.op_en      = oe;
        bus.op         = o;
        @(posedge clk);
        #1;
        bus.push_en = 1'b0;
        bus.op_en   = 1'b0;
        bus.op      = NOP;
    endtask

    task automatic push(input logic [WIDTH-1:0] v);
        cyc(1'b1, v, 1'b0, NOP);
    endtask

    task automatic op(input logic [2:0] o);
        cyc(1'b0, '0, 1'b1, o);
    endtask

    task automatic idle_cyc();
        cyc(1'b0, '0, 1'b0, NOP);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        bus.push_en    = 1'b0;
        bus.push_value = '0;
        bus.op_en      = 1'b0;
        bus.op         = NOP;
        do_reset();

        chk("rst_tos",   64'(bus.tos), 64'h0);
        chk("rst_nos",   64'(bus.nos), 64'h0);
        chk("rst_depth", 64'(bus.depth), 64'd0);
        chk("rst_empty", 64'(bus.empty), 64'd1);
        chk("rst_idle",  64'(bus.idle), 64'd1);
        chk("rst_ovf",   64'(bus.overflow), 64'd0);
        chk("rst_unf",   64'(bus.underflow), 64'd0);
        chk("rst_hwm",   64'(bus.hwm), 64'd0);

        // Three pushes: third spills 0x11 into the RAM
        push(56'h11);
        chk("p1_idle", 64'(bus.idle), 64'd1);
        chk("p1_tos",  64'(bus.tos), 64'h11);
        push(56'h22);
        chk("p2_idle", 64'(bus.idle), 64'd1);
        push(56'h33);
        chk("p3_idle",  64'(bus.idle), 64'd1);
        chk("p3_tos",   64'(bus.tos), 64'h33);
        chk("p3_nos",   64'(bus.nos), 64'h22);
        chk("p3_depth", 64'(bus.depth), 64'd3);

        // DROP with refill from RAM
        op(DROP);
        chk("d1_idle_low", 64'(bus.idle), 64'd0);
        chk("d1_tos",      64'(bus.tos), 64'h22);
        chk("d1_depth",    64'(bus.depth), 64'd2);
        idle_cyc();
        chk("d1_idle_back", 64'(bus.idle), 64'd1);
        chk("d1_nos_fill",  64'(bus.nos), 64'h11);
        chk("d1_tos_hold",  64'(bus.tos), 64'h22);
        op(DROP);
        chk("d2_idle",  64'(bus.idle), 64'd1);
        chk("d2_tos",   64'(bus.tos), 64'h11);
        chk("d2_nos",   64'(bus.nos), 64'h0);
        chk("d2_depth", 64'(bus.depth), 64'd1);
        op(DROP);
        chk("d3_tos",   64'(bus.tos), 64'h0);
        chk("d3_empty", 64'(bus.empty), 64'd1);
        chk("d3_unf",   64'(bus.underflow), 64'd0);

        // Fill to capacity, then overflow
        for (int i = 1; i <= 4; i++)
            push(56'(i));
        chk("f_full",  64'(bus.full), 64'd1);
        chk("f_tos",   64'(bus.tos), 64'h4);
        chk("f_nos",   64'(bus.nos), 64'h3);
        chk("f_ovf0",  64'(bus.overflow), 64'd0);
        push(56'h5);
        chk("o_ovf",   64'(bus.overflow), 64'd1);
        chk("o_tos",   64'(bus.tos), 64'h4);
        chk("o_nos",   64'(bus.nos), 64'h3);
        chk("o_depth", 64'(bus.depth), 64'd4);
        op(CLEAR);
        chk("c_depth", 64'(bus.depth), 64'd0);
        chk("c_tos",   64'(bus.tos), 64'h0);
        chk("c_ovf",   64'(bus.overflow), 64'd1);
        chk("c_unf",   64'(bus.underflow), 64'd0);

        // Underflow cases
        op(SWAP);
        chk("u_swap_unf",   64'(bus.underflow), 64'd1);
        chk("u_swap_depth", 64'(bus.depth), 64'd0);
        push(56'hA);
        op(OVER);
        chk("u_over_unf",   64'(bus.underflow), 64'd1);
        chk("u_over_depth", 64'(bus.depth), 64'd1);
        chk("u_over_tos",   64'(bus.tos), 64'hA);
        chk("u_over_nos",   64'(bus.nos), 64'h0);

        // Push beats a simultaneous op; requests in S_FILL are ignored
        op(CLEAR);
        push(56'hA);
        push(56'hB);
        cyc(1'b1, 56'hC, 1'b1, SWAP);
        chk("pc_tos",   64'(bus.tos), 64'hC);
        chk("pc_nos",   64'(bus.nos), 64'hB);
        chk("pc_depth", 64'(bus.depth), 64'd3);
        op(DROP);
        chk("pf_idle_low", 64'(bus.idle), 64'd0);
        push(56'hDD);
        chk("pf_idle",  64'(bus.idle), 64'd1);
        chk("pf_depth", 64'(bus.depth), 64'd2);
        chk("pf_tos",   64'(bus.tos), 64'hB);
        chk("pf_nos",   64'(bus.nos), 64'hA);

        // OVER, DUP to full, DROP refill, SWAP, undefined op
        op(OVER);
        chk("ov_tos",   64'(bus.tos), 64'hA);
        chk("ov_nos",   64'(bus.nos), 64'hB);
        chk("ov_depth", 64'(bus.depth), 64'd3);
        op(DUP);
        chk("dp_tos",  64'(bus.tos), 64'hA);
        chk("dp_nos",  64'(bus.nos), 64'hA);
        chk("dp_full", 64'(bus.full), 64'd1);
        op(DROP);
        idle_cyc();
        chk("dr_tos",   64'(bus.tos), 64'hA);
        chk("dr_nos",   64'(bus.nos), 64'hB);
        chk("dr_depth", 64'(bus.depth), 64'd3);
        op(SWAP);
        chk("sw_tos", 64'(bus.tos), 64'hB);
        chk("sw_nos", 64'(bus.nos), 64'hA);
        op(3'd6);
        chk("nop_tos",   64'(bus.tos), 64'hB);
        chk("nop_depth", 64'(bus.depth), 64'd3);
        chk("nop_idle",  64'(bus.idle), 64'd1);
        op(DROP);
        idle_cyc();
        op(DROP);
        chk("deep_tos", 64'(bus.tos), 64'hA);
        chk("deep_nos", 64'(bus.nos), 64'h0);

        // High-water mark from a fresh reset
        do_reset();
        push(56'h1);
        push(56'h2);
        push(56'h3);
        op(DROP);
        idle_cyc();
        op(DROP);
        push(56'h7);
        chk("h_depth", 64'(bus.depth), 64'd2);
        chk("h_tos",   64'(bus.tos), 64'h7);
        chk("h_nos",   64'(bus.nos), 64'h1);
`ifdef CORE_STACK_HWM_EN
        chk("h_hwm", 64'(bus.hwm), 64'd3);
`else
        chk("h_hwm_off", 64'(bus.hwm), 64'd0);
`endif

        // Asynchronous reset while a refill is pending
        push(56'h8);
        op(DROP);
        chk("ra_idle_low", 64'(bus.idle), 64'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("ra_tos",   64'(bus.tos), 64'h0);
        chk("ra_nos",   64'(bus.nos), 64'h0);
        chk("ra_depth", 64'(bus.depth), 64'd0);
        chk("ra_idle",  64'(bus.idle), 64'd1);
        chk("ra_hwm",   64'(bus.hwm), 64'd0);
        chk("ra_ovf",   64'(bus.overflow), 64'd0);
        chk("ra_unf",   64'(bus.underflow), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        push(56'h44);
        chk("post_tos",   64'(bus.tos), 64'h44);
        chk("post_depth", 64'(bus.depth), 64'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
